writeback_regfile: RTL

- Write-back end of the SEQ register-file interface. Holds the 15 Y86-64 program registers and commits valE/valM to dstE/dstM on each clock edge.
- Publishes the full register contents as the flattened 960-bit bus that decode reads (register i at bits [64i+63:64i]).
- Also owns the processor status register: holds the sticky halt state and freezes architectural state once a non-AOK status reaches write-back.

---
 rtl/writeback_regfile.sv | 105 ++++++++++
 1 files changed

// File: rtl/writeback_regfile.sv
// SEQ write-back stage: 15 Y86-64 program registers, processor status and sticky halt.
// Register contents are published flattened, register i at bits [64i+63:64i].

module regfile_entry #(
    parameter int                 DATA_W  = 64,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              we_e,
    input  logic              we_m,
    input  logic [DATA_W-1:0] val_e,
    input  logic [DATA_W-1:0] val_m,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] r_d, r_q;

    // M port has priority so popq %rsp leaves the popped value in the register
    always_comb begin
        r_d = r_q;
        if (we_m)      r_d = val_m;
        else if (we_e) r_d = val_e;
    end

    always_ff @(posedge Clk) begin
        if (Rst) r_q <= RST_VAL;
        else     r_q <= r_d;
    end

    assign q = r_q;
endmodule

module writeback_regfile #(
    parameter int                DATA_W   = 64,
    parameter int                NREG     = 15,
    parameter logic [DATA_W-1:0] RSP_INIT = 64'h0
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     wb_en,
    input  logic [3:0]               icode,
    input  logic                     cnd,
    input  logic [2:0]               stat,
    input  logic [3:0]               dstE,
    input  logic [3:0]               dstM,
    input  logic [DATA_W-1:0]        valE,
    input  logic [DATA_W-1:0]        valM,
    output logic [NREG*DATA_W-1:0]   regis,
    output logic [2:0]               stat_out,
    output logic                     halted
);
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [3:0] I_CMOV   = 4'h2;

    logic [2:0] stat_d, stat_q;
    logic       halted_d, halted_q;
    logic       commit;
    logic [3:0] eff_dste;

    // A not-taken cmov behaves as if it had no E destination
    assign eff_dste = (icode == I_CMOV && !cnd) ? R_NONE : dstE;
    assign commit   = wb_en && !halted_q && (stat == STAT_AOK);

    always_comb begin
        stat_d   = stat_q;
        halted_d = halted_q;
        if (wb_en && !halted_q && stat != STAT_AOK) begin
            stat_d   = stat;
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stat_q   <= STAT_AOK;
            halted_q <= 1'b0;
        end else begin
            stat_q   <= stat_d;
            halted_q <= halted_d;
        end
    end

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        localparam logic [3:0]        IDX = 4'(i);
        localparam logic [DATA_W-1:0] RV  = (i == 4) ? RSP_INIT : '0;
        logic we_e, we_m;

        assign we_e = commit && (eff_dste == IDX);
        assign we_m = commit && (dstM == IDX);

        regfile_entry #(.DATA_W(DATA_W), .RST_VAL(RV)) u_entry (
            .Clk   (Clk),
            .Rst   (Rst),
            .we_e  (we_e),
            .we_m  (we_m),
            .val_e (valE),
            .val_m (valM),
            .q     (regis[i*DATA_W +: DATA_W])
        );
    end

    assign stat_out = stat_q;
    assign halted   = halted_q;
endmodule
